// File: rtl/hazard_unit_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS hazard unit: forward selects,
// divider tracker states and syscall argument registers.
package mips_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_e;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_e;

  localparam int V0 = 2;
  localparam int A0 = 4;

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Pipeline-side signal bundle of the hazard unit; the datapath drives the
// master side and the hazard unit sits on the slave side.
interface hazard_unit_mc_if #(
  parameter int REG_W  = 5,
  parameter int PERF_W = 32
);
  logic [REG_W-1:0]  RsD, RtD;
  logic              BranchD, syscallD, MfOpInD, DivOpInD;
  logic [REG_W-1:0]  RsE, RtE, WriteRegE;
  logic              MemtoRegE, RegWriteE;
  logic [REG_W-1:0]  WriteRegM;
  logic              MemtoRegM, RegWriteM;
  logic [REG_W-1:0]  WriteRegW;
  logic              RegWriteW;
  logic              DivStartE;
  logic              StallF, StallD, FlushE;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              DivBusy, HiLoWriteE;
  logic [PERF_W-1:0] StallCount;

  modport master (
    output RsD, RtD, BranchD, syscallD, MfOpInD, DivOpInD,
           RsE, RtE, WriteRegE, MemtoRegE, RegWriteE,
           WriteRegM, MemtoRegM, RegWriteM, WriteRegW, RegWriteW, DivStartE,
    input  StallF, StallD, FlushE, ForwardAE, ForwardBE,
           DivBusy, HiLoWriteE, StallCount
  );

  modport slave (
    input  RsD, RtD, BranchD, syscallD, MfOpInD, DivOpInD,
           RsE, RtE, WriteRegE, MemtoRegE, RegWriteE,
           WriteRegM, MemtoRegM, RegWriteM, WriteRegW, RegWriteW, DivStartE,
    output StallF, StallD, FlushE, ForwardAE, ForwardBE,
           DivBusy, HiLoWriteE, StallCount
  );
endinterface

// File: rtl/hazard_unit_mc_div_tracker.sv
// Tracks the multi-cycle divider: DIV_LATENCY cycles from the start cycle to
// the single HI/LO write pulse, with DONE able to chain straight into BUSY.
module hazard_div_tracker
  import mips_hazard_pkg::*;
#(
  parameter int DIV_LATENCY = 8,
  parameter int CNT_W       = $clog2(DIV_LATENCY + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic div_start,
  output logic div_busy,
  output logic hilo_write
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DIV_LATENCY - 2);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal written here is defaulted first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hilo_write = 1'b0;
    unique case (state_q)
      DIV_IDLE: begin
        if (div_start) begin
          cnt_d   = LOAD_VAL;
          state_d = (LOAD_VAL == '0) ? DIV_DONE : DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        // Start cycle plus LOAD_VAL busy cycles, then the DONE cycle.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        hilo_write = 1'b1;
        if (div_start) begin
          cnt_d   = LOAD_VAL;
          state_d = (LOAD_VAL == '0) ? DIV_DONE : DIV_BUSY;
        end else begin
          state_d = DIV_IDLE;
        end
      end
      default: begin
        state_d = DIV_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Busy from the start cycle itself so a dependent mf/div in D stalls at once.
  assign div_busy = (state_q == DIV_BUSY) || ((state_q == DIV_IDLE) && div_start);

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage MIPS pipeline: forwarding, load-use/branch/
// syscall/HI-LO/divider stalls, divider tracking and a saturating stall counter.
module hazard_unit_mc
  import mips_hazard_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter int DIV_LATENCY = 8,
  parameter int CNT_W       = $clog2(DIV_LATENCY + 1),
  parameter int PERF_W      = 32,
  parameter int V0_REG      = V0,
  parameter int A0_REG      = A0
) (
  input logic            clk,
  input logic            rst_n,
  hazard_unit_mc_if.slave hz
);

  localparam logic [REG_W-1:0] V0_R = REG_W'(V0_REG);
  localparam logic [REG_W-1:0] A0_R = REG_W'(A0_REG);

  function automatic fwd_e fwd_sel(input logic [REG_W-1:0] src,
                                   input logic [REG_W-1:0] dst_m, input logic wr_m,
                                   input logic [REG_W-1:0] dst_w, input logic wr_w);
    if (src != '0 && src == dst_m && wr_m)      return FWD_M;
    else if (src != '0 && src == dst_w && wr_w) return FWD_W;
    else                                        return FWD_NONE;
  endfunction

  function automatic logic is_sys_reg(input logic [REG_W-1:0] r, input logic wr);
    return wr && (r == V0_R || r == A0_R);
  endfunction

  logic div_busy, hilo_write;
  logic lw_stall, branch_stall, sys_stall, mf_stall, div_stall, any_stall;
  logic [PERF_W-1:0] stall_count_q, stall_count_d;

  hazard_div_tracker #(
    .DIV_LATENCY (DIV_LATENCY),
    .CNT_W       (CNT_W)
  ) u_div_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_start  (hz.DivStartE),
    .div_busy   (div_busy),
    .hilo_write (hilo_write)
  );

  assign hz.ForwardAE = fwd_sel(hz.RsE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW);
  assign hz.ForwardBE = fwd_sel(hz.RtE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW);

  assign lw_stall = hz.MemtoRegE && (hz.RtE != '0) &&
                    ((hz.RsD == hz.RtE) || (hz.RtD == hz.RtE));

  // Branches resolve in D, so an ALU result in E or a load in M is still too late.
  assign branch_stall = hz.BranchD &&
      ((hz.RegWriteE && hz.WriteRegE != '0 &&
        (hz.WriteRegE == hz.RsD || hz.WriteRegE == hz.RtD)) ||
       (hz.MemtoRegM && hz.WriteRegM != '0 &&
        (hz.WriteRegM == hz.RsD || hz.WriteRegM == hz.RtD)));

  assign sys_stall = hz.syscallD &&
      (is_sys_reg(hz.WriteRegE, hz.RegWriteE) ||
       is_sys_reg(hz.WriteRegM, hz.RegWriteM) ||
       is_sys_reg(hz.WriteRegW, hz.RegWriteW) || div_busy);

  assign mf_stall  = hz.MfOpInD && (div_busy || hilo_write);
  assign div_stall = hz.DivOpInD && div_busy;
  assign any_stall = lw_stall || branch_stall || sys_stall || mf_stall || div_stall;

  assign hz.StallF     = any_stall;
  assign hz.StallD     = any_stall;
  assign hz.FlushE     = any_stall;
  assign hz.DivBusy    = div_busy;
  assign hz.HiLoWriteE = hilo_write;

  always_comb begin
    stall_count_d = stall_count_q;
    if (any_stall && (stall_count_q != '1)) stall_count_d = stall_count_q + PERF_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_count_q <= '0;
    else        stall_count_q <= stall_count_d;
  end

  assign hz.StallCount = stall_count_q;

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised next-generation hazard unit for the 5-stage MIPS pipeline.
- Adds a multi-cycle divider tracker (HI/LO scoreboard with countdown), structural stalls for back-to-back divides, and a saturating stall-cycle performance counter.
- Keeps load-use, branch and syscall stall detection and E-stage forwarding.
- Sits beside the datapath. Drives Fetch/Decode enables, the D/E flush, the E-stage forwarding muxes and the divider hold.

Parameters:
- REG_W, 5, register-address width.
- DIV_LATENCY, 8, cycles a divide occupies the E stage (>=2).
- CNT_W, $clog2(DIV_LATENCY+1), width of the divide countdown.
- PERF_W, 32, width of the stall-cycle counter.
- V0_REG, 2, syscall argument register.
- A0_REG, 4, syscall argument register.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- RsD, RtD  in  REG_W  Decode source registers.
- BranchD, syscallD, MfOpInD, DivOpInD  in  1  Decode has branch / syscall / mfhi-mflo / div-divu.
- RsE, RtE, WriteRegE  in  REG_W  Execute registers.
- MemtoRegE, RegWriteE  in  1  Execute control.
- WriteRegM  in  REG_W  Mem destination.
- MemtoRegM, RegWriteM  in  1  Mem control.
- WriteRegW  in  REG_W  Writeback destination.
- RegWriteW  in  1  Writeback control.
- DivStartE  in  1  a divide is in E this cycle and is not being flushed.
- StallF, StallD  out  1  active-high hold of Fetch / Decode registers.
- FlushE  out  1  active-high bubble insert into D/E.
- ForwardAE, ForwardBE  out  2  2'b10 from M, 2'b01 from W, 2'b00 register file.
- DivBusy  out  1  divider occupied; datapath holds E/M for the divide.
- HiLoWriteE  out  1  one-cycle pulse: divider result valid, HI/LO written.
- StallCount  out  PERF_W  saturating count of cycles with StallD high.

Behaviour:
- Reset (async, rst_n=0):
  - Divide FSM = IDLE, countdown = 0, StallCount = 0.
  - DivBusy = 0, HiLoWriteE = 0.
  - Combinational outputs follow inputs from the first cycle.
- Forwarding (combinational):
  - ForwardAE = 10 if RsE!=0 && RsE==WriteRegM && RegWriteM.
  - Otherwise ForwardAE = 01 if RsE!=0 && RsE==WriteRegW && RegWriteW.
  - Otherwise ForwardAE = 00.
  - ForwardBE uses RtE with the same rules. M has priority over W.
- lwStall = MemtoRegE && RtE!=0 && (RsD==RtE || RtD==RtE).
- branchStall = BranchD && ((RegWriteE && WriteRegE!=0 && WriteRegE∈{RsD,RtD}) || (MemtoRegM && WriteRegM!=0 && WriteRegM∈{RsD,RtD})).
- sysStall = syscallD && (any of E/M/W writes V0_REG or A0_REG with its RegWrite high || DivBusy).
- mfStall = MfOpInD && (DivBusy || HiLoWriteE).
- divStall = DivOpInD && DivBusy, a structural hazard.
- anyStall = OR of all five. StallF = StallD = FlushE = anyStall, all active-high.
- Divide FSM (registered): IDLE → BUSY → DONE.
  - IDLE: on DivStartE, load countdown = DIV_LATENCY-2 and go to BUSY.
  - BUSY: decrement each cycle; when countdown==0, go to DONE.
  - DONE: one cycle, HiLoWriteE=1, then IDLE.
  - DONE → BUSY directly is allowed if DivStartE is high in DONE.
- DivBusy = (state==BUSY) || (state==IDLE && DivStartE), i.e. asserted from the start cycle.
- Total occupancy = DIV_LATENCY cycles from DivStartE to HiLoWriteE inclusive.
- DivStartE while BUSY is a protocol violation. Bench asserts; RTL ignores it.
- StallCount increments each cycle StallD=1 and saturates at all-ones.
- rst_n low mid-divide: FSM returns to IDLE immediately; no HiLoWriteE pulse.

Decomposition:
- Package mips_hazard_pkg:
  - Forward-select encodings FWD_NONE=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - Divide-state enum {DIV_IDLE, DIV_BUSY, DIV_DONE}.
  - Register constants V0/A0.
- One sub-module, hazard_div_tracker: the FSM, countdown and DivBusy/HiLoWriteE generation.
- Top level holds the combinational stall/forward logic and the perf counter.

Test Plan:
- Forwarding:
  - RsE=5, WriteRegM=5, RegWriteM=1, WriteRegW=5, RegWriteW=1 → ForwardAE=10.
  - Clear RegWriteM → 01.
  - RsE=0 → 00.
- Load-use: MemtoRegE=1, RtE=8, RsD=8 → StallF=StallD=FlushE=1 for that cycle; StallCount increments by 1.
- Divide, DIV_LATENCY=8:
  - Pulse DivStartE at cycle 0 → DivBusy=1 cycles 0–6; HiLoWriteE=1 exactly at cycle 7; IDLE at cycle 8.
  - MfOpInD held high → StallD=1 cycles 0–7, and 0 at cycle 8.
- Back-to-back divide: DivOpInD=1 during BUSY → StallD=1. DivStartE in the DONE cycle → re-enters BUSY with no idle gap.
- Syscall: syscallD=1, WriteRegM=2, RegWriteM=1 → stall. Next cycle, no v0/a0 writers and divider idle → stall released.
- Reset mid-divide at cycle 3 → DivBusy=0 immediately, no HiLoWriteE, StallCount=0. Also preload near all-ones (PERF_W=4, 20 stall cycles) → StallCount holds 15.
